// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S frame scheduler: FSM states,
// accumulator sizing and the final saturation step.
package i2s_pkg;

    typedef enum logic [1:0] {IDLE, SEL, WAIT, COMMIT} state_e;

    // One sign bit of headroom beyond the worst-case sum of all tracks.
    function automatic int acc_width(input int width, input int num_tracks);
        return width + $clog2(num_tracks) + 1;
    endfunction

    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/i2s_frame_scheduler_accum.sv
// Left/right mixing accumulators: clear, add a stereo sample, and present
// the sums saturated to the sample width.
module stereo_sat_accum
    import i2s_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_TRACKS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    add_i,
    input  logic signed [WIDTH-1:0] add_l_i,
    input  logic signed [WIDTH-1:0] add_r_i,
    output logic signed [WIDTH-1:0] sat_l_o,
    output logic signed [WIDTH-1:0] sat_r_o
);
    localparam int AW = acc_width(WIDTH, NUM_TRACKS);

    logic signed [AW-1:0] acc_l_q, acc_r_q, acc_l_d, acc_r_d;

    always_comb begin
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        if (clr_i) begin
            acc_l_d = '0;
            acc_r_d = '0;
        end else if (add_i) begin
            acc_l_d = acc_l_q + AW'(add_l_i);
            acc_r_d = acc_r_q + AW'(add_r_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else begin
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
        end
    end

    assign sat_l_o = WIDTH'(sat_to_width(64'(acc_l_q), WIDTH));
    assign sat_r_o = WIDTH'(sat_to_width(64'(acc_r_q), WIDTH));

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Once-per-frame sample fetch: on a ws rise, poll each unmuted track, mix
// with saturation and commit to the transmitter before the next ws fall.
module i2s_frame_scheduler
    import i2s_pkg::*;
#(
    parameter int  WIDTH      = 16,
    parameter int  NUM_TRACKS = 4,
    parameter int  TIMEOUT    = 32,
    localparam int TW         = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                    mclk_i,
    input  logic                    rst_i,
    input  logic                    ws_i,
    input  logic [NUM_TRACKS-1:0]   track_mute_i,
    output logic                    req_valid_o,
    output logic [TW-1:0]           req_track_o,
    input  logic                    rsp_valid_i,
    input  logic signed [WIDTH-1:0] rsp_l_i,
    input  logic signed [WIDTH-1:0] rsp_r_i,
    output logic signed [WIDTH-1:0] tx_data_l_o,
    output logic signed [WIDTH-1:0] tx_data_r_o,
    output logic                    frame_commit_o,
    output logic                    underrun_o,
    output logic                    late_o,
    output logic [15:0]             err_count_o
);
    localparam int TMW = $clog2(TIMEOUT + 1);

    state_e                  state_q;
    logic                    ws_q, tmo_flag_q;
    logic [TW-1:0]           idx_q;
    logic [TMW-1:0]          timer_q;
    logic                    req_valid_q, frame_commit_q, underrun_q, late_q;
    logic [TW-1:0]           req_track_q;
    logic signed [WIDTH-1:0] tx_l_q, tx_r_q, sat_l, sat_r;
    logic [15:0]             err_q, err_inc;
    logic                    rise, fall, last, acc_add;

    assign rise    = ws_i & ~ws_q;
    assign fall    = ~ws_i & ws_q;
    assign last    = (idx_q == TW'(NUM_TRACKS - 1));
    assign err_inc = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
    // An abort in the same cycle as a response discards that response.
    assign acc_add = (state_q == WAIT) && rsp_valid_i && !rise && !fall;

    stereo_sat_accum #(.WIDTH(WIDTH), .NUM_TRACKS(NUM_TRACKS)) u_accum (
        .clk_i   (mclk_i),
        .rst_i   (rst_i),
        .clr_i   (rise),
        .add_i   (acc_add),
        .add_l_i (rsp_l_i),
        .add_r_i (rsp_r_i),
        .sat_l_o (sat_l),
        .sat_r_o (sat_r)
    );

    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            ws_q           <= 1'b0;
            tmo_flag_q     <= 1'b0;
            idx_q          <= '0;
            timer_q        <= '0;
            req_valid_q    <= 1'b0;
            req_track_q    <= '0;
            tx_l_q         <= '0;
            tx_r_q         <= '0;
            frame_commit_q <= 1'b0;
            underrun_q     <= 1'b0;
            late_q         <= 1'b0;
            err_q          <= '0;
        end else begin
            ws_q           <= ws_i;
            frame_commit_q <= 1'b0;
            underrun_q     <= 1'b0;
            late_q         <= 1'b0;
            if (rise && state_q != IDLE) begin
                // Previous fetch missed its window; abandon it and restart.
                req_valid_q <= 1'b0;
                late_q      <= 1'b1;
                err_q       <= err_inc;
                idx_q       <= '0;
                tmo_flag_q  <= 1'b0;
                state_q     <= SEL;
            end else if (fall && (state_q == SEL || state_q == WAIT)) begin
                req_valid_q <= 1'b0;
                late_q      <= 1'b1;
                err_q       <= err_inc;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (rise) begin
                        idx_q      <= '0;
                        tmo_flag_q <= 1'b0;
                        state_q    <= SEL;
                    end
                    SEL: if (track_mute_i[idx_q]) begin
                        if (last) state_q <= COMMIT;
                        else      idx_q   <= idx_q + 1'b1;
                    end else begin
                        req_valid_q <= 1'b1;
                        req_track_q <= idx_q;
                        timer_q     <= '0;
                        state_q     <= WAIT;
                    end
                    WAIT: if (rsp_valid_i || timer_q == TMW'(TIMEOUT - 1)) begin
                        req_valid_q <= 1'b0;
                        if (!rsp_valid_i) begin
                            tmo_flag_q <= 1'b1;
                            err_q      <= err_inc;
                        end
                        if (last) state_q <= COMMIT;
                        else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= SEL;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                    COMMIT: begin
                        tx_l_q         <= sat_l;
                        tx_r_q         <= sat_r;
                        frame_commit_q <= 1'b1;
                        underrun_q     <= tmo_flag_q;
                        state_q        <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign req_valid_o    = req_valid_q;
    assign req_track_o    = req_track_q;
    assign tx_data_l_o    = tx_l_q;
    assign tx_data_r_o    = tx_r_q;
    assign frame_commit_o = frame_commit_q;
    assign underrun_o     = underrun_q;
    assign late_o         = late_q;
    assign err_count_o    = err_q;

endmodule
